// File: rtl/geofence_feeder.sv
// Staging FIFO in front of the geofence evaluator: buffers records in groups of six,
// replays each complete group, and returns tagged verdicts with hung-evaluator timeout.
module geofence_feeder #(
    parameter int unsigned GROUPS  = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    input  logic [9:0]  in_x_i,
    input  logic [9:0]  in_y_i,
    input  logic [10:0] in_r_i,
    output logic        in_ready_o,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic [10:0] r_o,
    output logic        fence_rst_o,
    input  logic        fence_valid_i,
    input  logic        fence_inside_i,
    output logic        res_valid_o,
    output logic        res_inside_o,
    output logic        res_err_o,
    output logic [7:0]  res_tag_o
);
    localparam int unsigned GRP   = 6;
    localparam int unsigned DEPTH = GRP * GROUPS;
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TAGW  = 8;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [10:0] r;
    } rec_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    rec_t            mem_q [DEPTH];
    rec_t            in_rec, head, out_rec;
    rec_t            last_q, last_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      k_q, k_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [TAGW-1:0] tag_q, tag_d, res_tag_q, res_tag_d;
    logic            res_valid_q, res_valid_d;
    logic            res_inside_q, res_inside_d;
    logic            res_err_q, res_err_d;
    logic            push, pop, grp_ready;

    assign in_ready_o   = (cnt_q < CW'(DEPTH));
    assign fence_rst_o  = (state_q == S_IDLE);
    assign x_o          = out_rec.x;
    assign y_o          = out_rec.y;
    assign r_o          = out_rec.r;
    assign res_valid_o  = res_valid_q;
    assign res_inside_o = res_inside_q;
    assign res_err_o    = res_err_q;
    assign res_tag_o    = res_tag_q;

    // FIFO bookkeeping; popping happens only while a group is being replayed
    always_comb begin
        in_rec    = '{x: in_x_i, y: in_y_i, r: in_r_i};
        push      = in_valid_i && in_ready_o;
        pop       = (state_q == S_SEND);
        head      = mem_q[rd_ptr_q];
        grp_ready = (cnt_q >= CW'(GRP));
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    // WAIT shows the last replayed record from a holding copy, since its slot may be refilled
    always_comb begin
        case (state_q)
            S_SEND:  out_rec = head;
            S_WAIT:  out_rec = last_q;
            default: out_rec = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        timer_d      = timer_q;
        tag_d        = tag_q;
        last_d       = last_q;
        res_valid_d  = 1'b0;
        res_inside_d = 1'b0;
        res_err_d    = 1'b0;
        res_tag_d    = res_tag_q;
        case (state_q)
            S_IDLE: begin
                if (grp_ready) begin
                    state_d = S_SEND;
                    k_d     = 3'd0;
                end
            end
            S_SEND: begin
                k_d    = k_q + 3'd1;
                last_d = head;
                if (k_q == 3'd5) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (fence_valid_i) begin
                    res_valid_d  = 1'b1;
                    res_inside_d = fence_inside_i;
                    res_tag_d    = tag_q;
                    tag_d        = tag_q + TAGW'(1);
                    state_d      = grp_ready ? S_SEND : S_IDLE;
                    k_d          = 3'd0;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    res_tag_d   = tag_q;
                    tag_d       = tag_q + TAGW'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            k_q          <= '0;
            timer_q      <= '0;
            tag_q        <= '0;
            last_q       <= '0;
            res_valid_q  <= 1'b0;
            res_inside_q <= 1'b0;
            res_err_q    <= 1'b0;
            res_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            timer_q      <= timer_d;
            tag_q        <= tag_d;
            last_q       <= last_d;
            res_valid_q  <= res_valid_d;
            res_inside_q <= res_inside_d;
            res_err_q    <= res_err_d;
            res_tag_q    <= res_tag_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_rec;
        end
    end
endmodule
